pmem_scheduler: RTL

Shares the single cacheline-adaptor port between the instruction cache and the data cache, and adds a one-line next-line prefetch buffer per cache. A demand read that hits its cache's buffer is answered without a memory access. After every demand read, the block issues a prefetch of the following 32-byte line. It replaces the plain memory arbiter between the L1 caches and the cacheline adaptor.

---
 rtl/pmem_scheduler_pkg.sv | 30 +++
 rtl/pmem_scheduler_if.sv | 43 ++++
 rtl/pmem_scheduler_pf_line_buffer.sv | 41 ++++
 rtl/pmem_scheduler.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pmem_scheduler_pkg.sv
// Shared types for the pmem scheduler: FSM states, requester ids, line/tag types.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pmem_sched_pkg;

  localparam int TAG_W    = 27;
  localparam int OFFSET_W = 5;

  typedef logic [255:0]     line_t;
  typedef logic [TAG_W-1:0] tag_t;

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    RESP,
    PREFETCH
  } sched_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } requester_e;

  // Line-aligned byte address for a tag.
  function automatic logic [31:0] line_addr(input tag_t tag);
    return {tag, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pmem_scheduler_if.sv
// Bundle of cache-side and adaptor-side signals around the pmem scheduler.
// Latency: n/a (wiring only).
// Backpressure: requests are held until their resp pulse; pmem strobes held until pmem_resp.
interface pmem_scheduler_if;
  logic [31:0]  icache_address;
  logic         icache_mem_read;
  logic         icache_mem_resp;
  logic [255:0] icache_rdata;

  logic [31:0]  dcache_address;
  logic [255:0] dcache_wdata;
  logic         dcache_mem_read;
  logic         dcache_mem_write;
  logic         dcache_mem_resp;
  logic [255:0] dcache_rdata;

  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_read;
  logic         pmem_write;

  // Scheduler view.
  modport slave (
    input  icache_address, icache_mem_read,
    output icache_mem_resp, icache_rdata,
    input  dcache_address, dcache_wdata, dcache_mem_read, dcache_mem_write,
    output dcache_mem_resp, dcache_rdata,
    input  pmem_resp, pmem_rdata,
    output pmem_address, pmem_wdata, pmem_read, pmem_write
  );

  // Caches and adaptor view.
  modport master (
    output icache_address, icache_mem_read,
    input  icache_mem_resp, icache_rdata,
    output dcache_address, dcache_wdata, dcache_mem_read, dcache_mem_write,
    input  dcache_mem_resp, dcache_rdata,
    output pmem_resp, pmem_rdata,
    input  pmem_address, pmem_wdata, pmem_read, pmem_write
  );
endinterface

// File: rtl/pmem_scheduler_pf_line_buffer.sv
// One tagged prefetch line (valid/tag/data) with load, tag-matched invalidate, combinational hit.
// Latency: hit/data combinational from lookup tag; load/invalidate take effect on the next edge.
// Backpressure: none; load wins over invalidate if both are asserted.
module pf_line_buffer
  import pmem_sched_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  tag_t  i_load_tag,
  input  line_t i_load_data,
  input  logic  i_inv,
  input  tag_t  i_inv_tag,
  input  tag_t  i_lookup_tag,
  output logic  o_hit,
  output line_t o_data
);

  logic  r_valid;
  tag_t  r_tag;
  line_t r_data;

  // Line state: fill from a completed prefetch, drop on a write to the same line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_tag   <= i_load_tag;
      r_data  <= i_load_data;
    end else if (i_inv && r_valid && (r_tag == i_inv_tag)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_data = r_data;

endmodule

// File: rtl/pmem_scheduler.sv
// Round-robin I/D arbiter onto one cacheline-adaptor port, with a next-line prefetch buffer per cache.
// Latency: buffer hit resp 1 cycle after request; miss/write resp N+2 cycles (N = adaptor latency).
// Backpressure: requests wait in IDLE while a demand or prefetch is in flight; prefetches are never aborted.
module pmem_scheduler
  import pmem_sched_pkg::*;
#(
  parameter bit PREFETCH_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  pmem_scheduler_if.slave bus
);

  sched_state_t r_state, w_state_nxt;
  requester_e   r_last_grant, w_win;
  tag_t         r_tag;
  logic         r_is_write;
  line_t        r_resp_data;

  logic  w_i_req, w_d_req, w_any_req;
  logic  w_win_write, w_win_hit;
  tag_t  w_i_tag, w_d_tag, w_win_tag, w_pf_tag;
  line_t w_win_data;
  logic  w_i_hit, w_d_hit;
  line_t w_i_data, w_d_data;
  logic  w_load_i, w_load_d, w_inv;
  logic  w_unused;

  assign w_i_req   = bus.icache_mem_read;
  assign w_d_req   = bus.dcache_mem_read | bus.dcache_mem_write;
  assign w_any_req = w_i_req | w_d_req;
  assign w_i_tag   = bus.icache_address[31:OFFSET_W];
  assign w_d_tag   = bus.dcache_address[31:OFFSET_W];
  assign w_pf_tag  = r_tag + 1'b1;
  assign w_unused  = ^{bus.icache_address[OFFSET_W-1:0], bus.dcache_address[OFFSET_W-1:0]};

  // Winner selection: on a tie, whoever was not granted last time goes.
  always_comb begin
    w_win = REQ_I;
    if (w_i_req && w_d_req) begin
      w_win = (r_last_grant == REQ_I) ? REQ_D : REQ_I;
    end else if (w_d_req) begin
      w_win = REQ_D;
    end
    w_win_tag   = (w_win == REQ_D) ? w_d_tag : w_i_tag;
    // A write takes priority if the D side ever raises both strobes.
    w_win_write = (w_win == REQ_D) && bus.dcache_mem_write;
    w_win_hit   = PREFETCH_EN && ((w_win == REQ_D) ? w_d_hit : w_i_hit);
    w_win_data  = (w_win == REQ_D) ? w_d_data : w_i_data;
  end

  pf_line_buffer u_ibuf (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load_i),
    .i_load_tag   (w_pf_tag),
    .i_load_data  (bus.pmem_rdata),
    .i_inv        (w_inv),
    .i_inv_tag    (w_d_tag),
    .i_lookup_tag (w_i_tag),
    .o_hit        (w_i_hit),
    .o_data       (w_i_data)
  );

  pf_line_buffer u_dbuf (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_load_d),
    .i_load_tag   (w_pf_tag),
    .i_load_data  (bus.pmem_rdata),
    .i_inv        (w_inv),
    .i_inv_tag    (w_d_tag),
    .i_lookup_tag (w_d_tag),
    .o_hit        (w_d_hit),
    .o_data       (w_d_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus all outputs, decoded from registered state only.
  always_comb begin
    w_state_nxt         = r_state;
    w_load_i            = 1'b0;
    w_load_d            = 1'b0;
    w_inv               = 1'b0;
    bus.pmem_read       = 1'b0;
    bus.pmem_write      = 1'b0;
    bus.pmem_address    = '0;
    bus.pmem_wdata      = '0;
    bus.icache_mem_resp = 1'b0;
    bus.dcache_mem_resp = 1'b0;
    bus.icache_rdata    = '0;
    bus.dcache_rdata    = '0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          if (w_win_write)    w_state_nxt = MEM_WR;
          else if (w_win_hit) w_state_nxt = RESP;
          else                w_state_nxt = MEM_RD;
        end
      end
      MEM_RD: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = line_addr(r_tag);
        if (bus.pmem_resp) w_state_nxt = RESP;
      end
      MEM_WR: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = line_addr(r_tag);
        bus.pmem_wdata   = bus.dcache_wdata;
        if (bus.pmem_resp) begin
          w_inv       = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (r_last_grant == REQ_I) begin
          bus.icache_mem_resp = 1'b1;
          bus.icache_rdata    = r_resp_data;
        end else begin
          bus.dcache_mem_resp = 1'b1;
          bus.dcache_rdata    = r_resp_data;
        end
        // No prefetch past the top line of the address space.
        if (!r_is_write && PREFETCH_EN && (r_tag != {TAG_W{1'b1}})) w_state_nxt = PREFETCH;
        else                                                       w_state_nxt = IDLE;
      end
      PREFETCH: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = line_addr(w_pf_tag);
        if (bus.pmem_resp) begin
          w_load_i    = (r_last_grant == REQ_I);
          w_load_d    = (r_last_grant == REQ_D);
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Grant bookkeeping and response data capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= REQ_I;
      r_tag        <= '0;
      r_is_write   <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_last_grant <= w_win;
            r_tag        <= w_win_tag;
            r_is_write   <= w_win_write;
            if (!w_win_write && w_win_hit) r_resp_data <= w_win_data;
          end
        end
        MEM_RD: if (bus.pmem_resp) r_resp_data <= bus.pmem_rdata;
        MEM_WR: if (bus.pmem_resp) r_resp_data <= '0;
        default: ;
      endcase
    end
  end

endmodule
